bin2bcd_serial: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_serial.sv | 162 ++++++++++++++++
 tb/tb_bin2bcd_serial.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: digit width,
// add-3 threshold and FSM state encoding.
package bin2bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADD3_VALUE  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit pre-shift correction: adds 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + ADD3_VALUE) : i_digit;

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock, with
// signed mode and overflow flag. Optional leading-zero mask via BIN2BCD_BLANK_EN.
module bin2bcd_serial
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      signedin,
  input  logic [WIDTH-1:0]          binin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcdout,
  output logic                      negout,
`ifdef BIN2BCD_BLANK_EN
  output logic [DIGITS-1:0]         blankout,
`endif
  output logic                      overflow
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_mag;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sign;
  logic               r_ovf_scratch;
  logic [CNT_W-1:0]   r_count;
  logic [ACC_W-1:0]   r_bcdout;
  logic               r_negout;
  logic               r_overflow;

  logic               w_neg_in;
  logic [WIDTH-1:0]   w_mag_in;
  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_shifted;
  logic               w_carry;
  logic               w_last;

  assign w_neg_in = signedin & binin[WIDTH-1];
  assign w_mag_in = w_neg_in ? (~binin + ONE) : binin;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[DIGIT_W*g +: DIGIT_W]),
      .o_digit (w_adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  // The top bit of the corrected accumulator is what falls off on this shift.
  assign w_acc_shifted = {w_adj[ACC_W-2:0], r_mag[WIDTH-1]};
  assign w_carry       = w_adj[ACC_W-1];
  assign w_last        = (r_count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Results are captured on the edge that enters DONE so they are already
  // stable for the whole cycle in which done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag         <= '0;
      r_acc         <= '0;
      r_sign        <= 1'b0;
      r_ovf_scratch <= 1'b0;
      r_count       <= '0;
      r_bcdout      <= '0;
      r_negout      <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mag         <= w_mag_in;
            r_sign        <= w_neg_in;
            r_acc         <= '0;
            r_ovf_scratch <= 1'b0;
            r_count       <= '0;
          end
        end
        ST_SHIFT: begin
          r_acc         <= w_acc_shifted;
          r_mag         <= r_mag << 1;
          r_ovf_scratch <= r_ovf_scratch | w_carry;
          r_count       <= r_count + 1'b1;
          if (w_last) begin
            r_bcdout   <= w_acc_shifted;
            r_negout   <= r_sign;
            r_overflow <= r_ovf_scratch | w_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bcdout   = r_bcdout;
  assign negout   = r_negout;
  assign overflow = r_overflow;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] w_blank;
  logic [DIGITS-1:0] r_blank;

  // Digit i is blank when it and every digit above it are zero; units never blank.
  assign w_blank[0] = 1'b0;
  for (genvar g = 1; g < DIGITS; g++) begin : g_blank
    assign w_blank[g] = (w_acc_shifted[ACC_W-1:DIGIT_W*g] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= '0;
    end else if ((r_state == ST_SHIFT) && w_last) begin
      r_blank <= w_blank;
    end
  end

  assign blankout = r_blank;
`endif

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Scoreboard bench for bin2bcd_serial: a 3-digit and a 2-digit instance share
// stimulus; expected results come from an arithmetic decimal model.
module tb_bin2bcd_serial;

  localparam int WIDTH = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signedin;
  logic [7:0]  binin;

  logic        busy3, done3, neg3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, neg2, ovf2;
  logic [7:0]  bcd2;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank3;
  logic [1:0]  blank2;
`endif

  typedef struct {
    int unsigned cyc;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;
    logic        neg;
    logic        ovf3;
    logic        ovf2;
    logic [2:0]  blank3;
    logic [1:0]  blank2;
  } exp_t;

  exp_t        expQ[$];
  int unsigned cyc;
  int          checks;
  int          passes;

  bin2bcd_serial #(.WIDTH(WIDTH), .DIGITS(3)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .signedin (signedin),
    .binin    (binin),
    .busy     (busy3),
    .done     (done3),
    .bcdout   (bcd3),
    .negout   (neg3),
`ifdef BIN2BCD_BLANK_EN
    .blankout (blank3),
`endif
    .overflow (ovf3)
  );

  bin2bcd_serial #(.WIDTH(WIDTH), .DIGITS(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .signedin (signedin),
    .binin    (binin),
    .busy     (busy2),
    .done     (done2),
    .bcdout   (bcd2),
    .negout   (neg2),
`ifdef BIN2BCD_BLANK_EN
    .blankout (blank2),
`endif
    .overflow (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] toBcd(input int mag, input int digits);
    logic [11:0] r = '0;
    int v = mag % pow10(digits);
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] toBlank(input int mag, input int digits);
    logic [2:0] r = '0;
    int v = mag % pow10(digits);
    for (int i = 1; i < digits; i++) r[i] = (v < pow10(i));
    return r;
  endfunction

  // Decimal reference: magnitude of the (optionally signed) input, split into digits.
  task automatic pushExpected(input logic [7:0] bin, input logic sgn);
    exp_t e;
    int   mag;
    logic [2:0] b2;
    logic [11:0] d2;
    e.neg     = sgn && (bin >= 8'd128);
    mag       = e.neg ? (256 - int'(bin)) : int'(bin);
    e.bcd3    = toBcd(mag, 3);
    d2        = toBcd(mag, 2);
    e.bcd2    = d2[7:0];
    e.ovf3    = (mag >= 1000);
    e.ovf2    = (mag >= 100);
    e.blank3  = toBlank(mag, 3);
    b2        = toBlank(mag, 2);
    e.blank2  = b2[1:0];
    e.cyc     = cyc + 1 + WIDTH;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] bin, input logic sgn);
    start    = 1'b1;
    binin    = bin;
    signedin = sgn;
    pushExpected(bin, sgn);
    @(negedge clk);
    start    = 1'b0;
    binin    = 8'($urandom);
    signedin = 1'($urandom_range(0, 1));
  endtask

  task automatic waitIdle();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("waitIdleTimeout", 32'(expQ.size()), 0);
    @(negedge clk);
  endtask

  // Monitor: every done pulse consumes one expected entry and is compared.
  always @(negedge clk) begin
    if (!reset) begin
      if (done3 || done2) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", {30'd0, done3, done2}, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("doneCycle", cyc, e.cyc);
          checkOutput("done3", 32'(done3), 1);
          checkOutput("done2", 32'(done2), 1);
          checkOutput("bcd3", 32'(bcd3), 32'(e.bcd3));
          checkOutput("neg3", 32'(neg3), 32'(e.neg));
          checkOutput("ovf3", 32'(ovf3), 32'(e.ovf3));
          checkOutput("bcd2", 32'(bcd2), 32'(e.bcd2));
          checkOutput("neg2", 32'(neg2), 32'(e.neg));
          checkOutput("ovf2", 32'(ovf2), 32'(e.ovf2));
`ifdef BIN2BCD_BLANK_EN
          checkOutput("blank3", 32'(blank3), 32'(e.blank3));
          checkOutput("blank2", 32'(blank2), 32'(e.blank2));
`endif
        end
      end else if (expQ.size() != 0 && cyc > expQ[0].cyc) begin
        checkOutput("missingDone", 0, 1);
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    int busyCnt;
    checks   = 0;
    passes   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    signedin = 1'b0;
    binin    = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rstBusy", 32'(busy3), 0);
    checkOutput("rstDone", 32'(done3), 0);
    checkOutput("rstBcd", 32'(bcd3), 0);
    checkOutput("rstNeg", 32'(neg3), 0);
    checkOutput("rstOvf", 32'(ovf3), 0);
    checkOutput("rstBusy2", 32'(busy2), 0);
`ifdef BIN2BCD_BLANK_EN
    checkOutput("rstBlank", 32'(blank3), 0);
`endif
    @(negedge clk);

    // Unsigned maximum plus busy-duration measurement.
    applyStimulus(8'd255, 1'b0);
    busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy3) busyCnt++;
      @(negedge clk);
    end
    checkOutput("busyCycles", busyCnt, WIDTH + 1);
    waitIdle();

    // Signed corners, overflow on the 2-digit instance, blanking values.
    applyStimulus(8'h80, 1'b1); waitIdle();
    applyStimulus(8'hFF, 1'b1); waitIdle();
    applyStimulus(8'h00, 1'b1); waitIdle();
    applyStimulus(8'd200, 1'b0); waitIdle();
    applyStimulus(8'd99, 1'b0); waitIdle();
    applyStimulus(8'd5, 1'b0); waitIdle();
    applyStimulus(8'd0, 1'b0); waitIdle();
    applyStimulus(8'd105, 1'b0); waitIdle();
    applyStimulus(8'h7F, 1'b1); waitIdle();
    applyStimulus(8'd100, 1'b0); waitIdle();

    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)));
      waitIdle();
    end

    // A start while busy must be dropped.
    applyStimulus(8'd42, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    binin = 8'd7;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Start held high: one acceptance every 10 cycles, binin churns meanwhile.
    for (int k = 0; k < 30; k++) begin
      start    = 1'b1;
      binin    = 8'($urandom);
      signedin = 1'($urandom_range(0, 1));
      if (k % 10 == 0) pushExpected(binin, signedin);
      @(negedge clk);
    end
    start = 1'b0;
    waitIdle();

    // Reset in the middle of a conversion: no done may follow.
    applyStimulus(8'd200, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midRstBusy", 32'(busy3), 0);
    checkOutput("midRstBcd", 32'(bcd3), 0);
    checkOutput("midRstBcd2", 32'(bcd2), 0);
    checkOutput("midRstOvf2", 32'(ovf2), 0);
    repeat (15) @(negedge clk);
    applyStimulus(8'd17, 1'b0);
    waitIdle();

    repeat (5) @(negedge clk);
    checkOutput("queueEmpty", 32'(expQ.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
